acumulador_4b: RTL

- Sequential accumulation stage for the 4-bit arithmetic datapath. It takes a stream of WIDTH-bit operands over a valid/ready handshake and sums a fixed batch of N_OPER operands.
- It then presents the batch sum plus a sticky carry-out on an output valid/ready handshake.
- It sits directly downstream of the operand source and directly upstream of the result consumer. It turns single-shot addition into batched, flow-controlled accumulation.

---
 rtl/acumulador_4b_pkg.sv | 18 +
 rtl/acumulador_4b_contador_oper.sv | 43 ++++
 rtl/acumulador_4b.sv | 101 ++++++++++
 3 files changed

// File: rtl/acumulador_4b_pkg.sv
// Shared types and defaults for the batched accumulator.
// Exposes FSM state encoding, default widths and counter sizing.
package acumulador_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACUM,
    SAIDA
  } estado_t;

  localparam int WIDTH_DEF  = 4;
  localparam int N_OPER_DEF = 4;

  function automatic int CNT_W(input int n_oper);
    return $clog2(n_oper + 1);
  endfunction

endpackage

// File: rtl/acumulador_4b_contador_oper.sv
// Operand counter: sync clear, increment enable, terminal flag.
// Ports: clk, rst, clr_i, inc_i -> count_o, term_o (count+1==N_OPER).
module contador_oper
  import acumulador_pkg::*;
#(
  parameter int N_OPER = N_OPER_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        inc_i,
  output logic [CNT_W(N_OPER)-1:0]    count_o,
  output logic                        term_o
);

  localparam int CW = CNT_W(N_OPER);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_nxt;

  assign cnt_nxt = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_nxt[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign term_o  = (cnt_nxt == (CW+1)'(N_OPER));

endmodule

// File: rtl/acumulador_4b.sv
// Batched accumulator: sums N_OPER operands, then holds the result.
// Ports: in_valid/in_ready/in_data in, out_valid/out_ready/out_soma/out_cout/out_count out.
module acumulador_4b
  import acumulador_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int N_OPER = N_OPER_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_soma,
  output logic                      out_cout,
  output logic [CNT_W(N_OPER)-1:0]  out_count
);

  estado_t          state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   sum;
  logic             in_fire, out_fire;
  logic             term;

  assign in_ready  = (state_q != SAIDA);
  assign out_valid = (state_q == SAIDA);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign sum       = {1'b0, acc_q} + {1'b0, in_data};

  contador_oper #(
    .N_OPER (N_OPER)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr || out_fire),
    .inc_i   (in_fire && !clr),
    .count_o (out_count),
    .term_o  (term)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      carry_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_fire) begin
            acc_d   = in_data;
            carry_d = 1'b0;
            state_d = term ? SAIDA : ACUM;
          end
        end
        ACUM: begin
          if (in_fire) begin
            acc_d   = sum[WIDTH-1:0];
            carry_d = carry_q | sum[WIDTH];
            if (term) state_d = SAIDA;
          end
        end
        SAIDA: begin
          if (out_fire) begin
            acc_d   = '0;
            carry_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          carry_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign out_soma = acc_q;
  assign out_cout = carry_q;

endmodule
